mac_l_acc: RTL and testbench

//   Q15 x Q15 multiply-accumulate stage producing a saturated Q31 (32-bit) dot product over a block of N_TAPS sample pairs.

---
 rtl/mac_l_acc_if.sv | 22 ++
 rtl/mac_l_acc.sv | 137 +++++++++++++
 tb/tb_mac_l_acc.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_l_acc_if.sv
// mac_l_acc_if: block-start, sample-pair handshake and block-result bundle for mac_l_acc.
interface mac_l_acc_if;
    logic                start;
    logic                in_valid;
    logic signed [15:0]  in_a;
    logic signed [15:0]  in_b;
    logic                in_ready;
    logic                busy;
    logic                out_valid;
    logic signed [31:0]  out_acc;
    logic                overflow;

    modport master (
        output start, in_valid, in_a, in_b,
        input  in_ready, busy, out_valid, out_acc, overflow
    );

    modport slave (
        input  start, in_valid, in_a, in_b,
        output in_ready, busy, out_valid, out_acc, overflow
    );
endinterface

// File: rtl/mac_l_acc.sv
// mac_l_acc: Q15 x Q15 multiply-accumulate over a block of N_TAPS pairs, producing a
// saturated Q31 dot product (L_mult then L_add, both saturating) with a sticky
// per-block overflow flag.
module mac_l_acc #(
    parameter int N_TAPS = 16
) (
    input  logic       clk,
    input  logic       reset,
    mac_l_acc_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = $clog2(N_TAPS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [DATA_W-1:0] Q15_MIN = 16'sh8000;
    localparam logic signed [ACC_W-1:0]  ACC_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [ACC_W-1:0]  ACC_MIN = 32'sh8000_0000;

    // L_mult: doubled product; only -1 * -1 leaves the Q31 range. Returns {sat, value}.
    function automatic logic [ACC_W:0] l_mult(input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
        logic signed [ACC_W-1:0] prod;
        prod = ACC_W'(a) * ACC_W'(b);
        if (a == Q15_MIN && b == Q15_MIN) return {1'b1, ACC_MAX};
        return {1'b0, prod <<< 1};
    endfunction

    // L_add: 33-bit sum clamped back into Q31. Returns {sat, value}.
    function automatic logic [ACC_W:0] l_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] sum;
        sum = (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
        if (sum[ACC_W] != sum[ACC_W-1]) return {1'b1, sum[ACC_W] ? ACC_MIN : ACC_MAX};
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] p_q, p_d;
    logic                    p_vld_q, p_vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overflow_q, overflow_d;

    logic                    accept;
    logic [ACC_W:0]          mult_r;
    logic [ACC_W:0]          add_r;

    assign accept        = bus.in_valid && (state_q == S_RUN);
    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.overflow  = overflow_q;

    // Next-state logic: block FSM, product stage, accumulate stage and result capture.
    always_comb begin
        mult_r      = l_mult(bus.in_a, bus.in_b);
        add_r       = l_add(acc_q, p_q);
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        p_vld_d     = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;

        // Stage 2: fold the registered product into the accumulator.
        if (p_vld_q) begin
            acc_d = add_r[ACC_W-1:0];
            ovf_d = ovf_q | add_r[ACC_W];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                // Stage 1: register the saturated product of an accepted pair.
                if (accept) begin
                    p_d     = mult_r[ACC_W-1:0];
                    p_vld_d = 1'b1;
                    ovf_d   = ovf_d | mult_r[ACC_W];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_TAPS - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                out_acc_d   = acc_q;
                overflow_d  = ovf_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any block in flight and clears the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            p_vld_q     <= p_vld_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_mac_l_acc.sv
// tb_mac_l_acc: scoreboard bench for mac_l_acc with a 4-tap and a 1-tap instance.
module tb_mac_l_acc;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   last_acc4;
    int   last_acc1;

    logic [31:0] exp_acc4[$];
    logic        exp_ovf4[$];
    logic [31:0] exp_acc1[$];
    logic        exp_ovf1[$];
    logic [31:0] m4_acc, m1_acc;
    logic        m4_ovf, m1_ovf;

    mac_l_acc_if f4();
    mac_l_acc_if f1();

    mac_l_acc #(.N_TAPS(4)) u4 (.clk(clk), .reset(reset), .bus(f4));
    mac_l_acc #(.N_TAPS(1)) u1 (.clk(clk), .reset(reset), .bus(f1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    // Reference: saturating dot product computed with wide integers.
    function automatic void model(input logic [15:0] a[$], input logic [15:0] b[$],
                                  output logic [31:0] acc, output logic ovf);
        longint s;
        longint x;
        longint y;
        longint p;
        s   = 0;
        ovf = 1'b0;
        for (int i = 0; i < a.size(); i++) begin
            x = longint'($signed(a[i]));
            y = longint'($signed(b[i]));
            if (x == -32768 && y == -32768) begin
                p   = MAXV;
                ovf = 1'b1;
            end else begin
                p = 2 * x * y;
            end
            s = s + p;
            if (s > MAXV) begin
                s   = MAXV;
                ovf = 1'b1;
            end else if (s < MINV) begin
                s   = MINV;
                ovf = 1'b1;
            end
        end
        acc = s[31:0];
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor for the 4-tap instance.
    always @(negedge clk) begin
        if (!reset && f4.out_valid) begin
            if (exp_acc4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u4_unexpected_out_valid: got out_valid=1, required no pending result");
            end else begin
                m4_acc = exp_acc4.pop_front();
                m4_ovf = exp_ovf4.pop_front();
                chk("u4_out_acc", f4.out_acc, m4_acc);
                chk("u4_overflow", 32'(f4.overflow), 32'(m4_ovf));
                chk("u4_latency", cyc, last_acc4 + 2);
            end
        end
    end

    // Monitor for the 1-tap instance.
    always @(negedge clk) begin
        if (!reset && f1.out_valid) begin
            if (exp_acc1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_out_valid: got out_valid=1, required no pending result");
            end else begin
                m1_acc = exp_acc1.pop_front();
                m1_ovf = exp_ovf1.pop_front();
                chk("u1_out_acc", f1.out_acc, m1_acc);
                chk("u1_overflow", 32'(f1.overflow), 32'(m1_ovf));
                chk("u1_latency", cyc, last_acc1 + 2);
            end
        end
    end

    task automatic send4(input logic [15:0] a[$], input logic [15:0] b[$],
                         input bit gaps, input bit junk, input bit restart);
        logic [31:0] ea;
        logic        eo;
        int          i;
        int          guard;
        bit          v;
        bit          took;
        model(a, b, ea, eo);
        exp_acc4.push_back(ea);
        exp_ovf4.push_back(eo);
        @(posedge clk); #1;
        if (junk) begin
            for (int j = 0; j < 2; j++) begin
                f4.in_valid = 1'b1;
                f4.in_a     = 16'($urandom);
                f4.in_b     = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        f4.start = 1'b1;
        @(posedge clk); #1;
        f4.start = 1'b0;
        i     = 0;
        guard = 0;
        while (i < a.size() && guard < 200) begin
            v           = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            f4.in_valid = v;
            f4.in_a     = v ? a[i] : 16'($urandom);
            f4.in_b     = v ? b[i] : 16'($urandom);
            f4.start    = restart && (i == 1);
            @(negedge clk);
            took = v && f4.in_ready;
            @(posedge clk); #1;
            if (took) begin
                i++;
                last_acc4 = cyc;
            end
            guard++;
        end
        f4.start = 1'b0;
        chk("u4_accept_count", i, a.size());
        chk("u4_in_ready_after_last", 32'(f4.in_ready), 32'd0);
        chk("u4_busy_in_drain", 32'(f4.busy), 32'd1);
        f4.in_valid = junk;
        f4.in_a     = 16'($urandom);
        f4.in_b     = 16'($urandom);
        @(posedge clk); #1;
        f4.start = restart;
        @(posedge clk); #1;
        f4.start    = 1'b0;
        f4.in_valid = 1'b0;
        chk("u4_busy_after_done", 32'(f4.busy), 32'd0);
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ea;
        logic        eo;
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        int          guard;
        bit          took;
        qa.push_back(a);
        qb.push_back(b);
        model(qa, qb, ea, eo);
        exp_acc1.push_back(ea);
        exp_ovf1.push_back(eo);
        @(posedge clk); #1;
        f1.start = 1'b1;
        @(posedge clk); #1;
        f1.start = 1'b0;
        took  = 1'b0;
        guard = 0;
        while (!took && guard < 50) begin
            f1.in_valid = 1'($urandom_range(0, 1));
            f1.in_a     = a;
            f1.in_b     = b;
            @(negedge clk);
            took = f1.in_valid && f1.in_ready;
            @(posedge clk); #1;
            if (took) last_acc1 = cyc;
            guard++;
        end
        f1.in_valid = 1'b1;
        chk("u1_accepted", 32'(took), 32'd1);
        chk("u1_in_ready_after_accept", 32'(f1.in_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        f1.in_valid = 1'b0;
        chk("u1_busy_after_done", 32'(f1.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        int          n;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        last_acc4   = 0;
        last_acc1   = 0;
        reset       = 1'b1;
        f4.start    = 1'b0;
        f4.in_valid = 1'b0;
        f4.in_a     = '0;
        f4.in_b     = '0;
        f1.start    = 1'b0;
        f1.in_valid = 1'b0;
        f1.in_a     = '0;
        f1.in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_acc", f4.out_acc, 32'd0);
        chk("rst_out_valid", 32'(f4.out_valid), 32'd0);
        chk("rst_overflow", 32'(f4.overflow), 32'd0);
        chk("rst_in_ready", 32'(f4.in_ready), 32'd0);
        chk("rst_busy", 32'(f4.busy), 32'd0);
        chk("rst_u1_out_acc", f1.out_acc, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Alternating products cancel to zero.
        qa = '{16'h0100, 16'hFF00, 16'h0100, 16'hFF00};
        qb = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
        send4(qa, qb, 1'b0, 1'b0, 1'b0);

        // Accumulator saturates positive.
        qa = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        qb = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        send4(qa, qb, 1'b0, 1'b0, 1'b0);

        // Single-tap: -1*-1 saturation, then a plain negative product.
        send1(16'h8000, 16'h8000);
        send1(16'h7FFF, 16'h8000);

        // Same data with gaps and dropped pairs, then gap-free.
        qa = '{16'h1234, 16'hF00D, 16'h7FFF, 16'h8000};
        qb = '{16'h0FED, 16'h2222, 16'h7FFF, 16'h0003};
        send4(qa, qb, 1'b1, 1'b1, 1'b0);
        send4(qa, qb, 1'b0, 1'b0, 1'b0);

        // Stray start in RUN and on DONE, then a back-to-back block.
        qa = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        qb = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        send4(qa, qb, 1'b1, 1'b0, 1'b1);
        qa = '{16'h0001, 16'hFFFF, 16'h0100, 16'h0003};
        qb = '{16'h0002, 16'h0005, 16'hFF00, 16'h0004};
        send4(qa, qb, 1'b0, 1'b0, 1'b0);

        // Randomised blocks on both instances.
        for (int blk = 0; blk < 10; blk++) begin
            qa.delete();
            qb.delete();
            for (int t = 0; t < 4; t++) begin
                qa.push_back(rnd16());
                qb.push_back(rnd16());
            end
            send4(qa, qb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int blk = 0; blk < 6; blk++) send1(rnd16(), rnd16());

        // Leave a nonzero result, then reset after two accepts.
        qa = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        qb = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        send4(qa, qb, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        f4.start = 1'b1;
        @(posedge clk); #1;
        f4.start    = 1'b0;
        f4.in_valid = 1'b1;
        f4.in_a     = 16'h1234;
        f4.in_b     = 16'h0101;
        repeat (2) @(posedge clk);
        #1;
        f4.in_valid = 1'b0;
        chk("mid_busy_before_reset", 32'(f4.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_acc", f4.out_acc, 32'd0);
        chk("mid_rst_out_valid", 32'(f4.out_valid), 32'd0);
        chk("mid_rst_overflow", 32'(f4.overflow), 32'd0);
        chk("mid_rst_in_ready", 32'(f4.in_ready), 32'd0);
        chk("mid_rst_busy", 32'(f4.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fresh block after the abandoned one.
        qa = '{16'h0400, 16'hC000, 16'h2000, 16'h7FFF};
        qb = '{16'h0400, 16'h2000, 16'hE000, 16'h0001};
        send4(qa, qb, 1'b1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        n = exp_acc4.size() + exp_acc1.size();
        chk("pending_results", n, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
